hex_display_ctrl: RTL
=====================

Name: hex_display_ctrl

Overview:
Parametrised Avalon-MM slave driving NUM_DIGITS seven-segment digits. Each digit shows either a hex nibble or a raw 7-bit segment pattern, with per-digit enable and per-digit hardware blink. Sits on the system bus in place of per-pair HEX PIO ports. The CPU writes values once; blanking and blink timing need no software involvement.

Parameters:
NUM_DIGITS, 6, number of digits driven; legal range 1..8.
BLINK_DIV, 25000000, clk cycles per blink half-period; must be >= 2.
ACTIVE_LOW, 1, 1 = segment driven low when lit; inverts all segment outputs.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
address  in  3  word address of register
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
byteenable  in  4  byte lanes for writes
writedata  in  32  write data
readdata  out  32  read data, zero wait states, combinational from address
hex_out  out  NUM_DIGITS*7  digit i occupies [7i+6:7i]; bit0 = seg a .. bit6 = seg g

Behaviour:
- Write condition: chipselect && !write_n. Only bytes whose byteenable bit is set are updated.
- Writes to unmapped addresses are ignored. Reads from them return 0. Unimplemented bits read 0 and ignore writes.
- Register map:
  - addr 0 VALUE (rw): nibble i = bits [4i+3:4i]. Reset 0.
  - addr 1 CTRL (rw):
    - [7:0] enable, reset = ones for implemented digits.
    - [15:8] blink mask, reset 0.
    - [23:16] raw_sel, reset 0.
  - addr 2 RAW_LO (rw): digits 0-3. addr 3 RAW_HI (rw): digits 4-7.
    - Digit k's pattern is at byte k mod 4, bits [6:0]. Bit 7 of each byte is unimplemented. Reset 0.
    - Patterns are active-high: 1 = segment lit.
  - addr 4 STATUS (ro): bit0 = blink_phase. Other bits 0.
- Blink timer:
  - Counter runs 0..BLINK_DIV-1.
  - On the wrap to 0, blink_phase toggles.
  - Any CTRL write with byteenable[1]=1 forces counter=0 and blink_phase=0 on that clock edge.
  - Counter and phase reset to 0.
- Per-digit segment selection, highest priority first:
  1. enable[i]=0 → all segments off.
  2. blink[i]=1 and blink_phase=1 → all segments off.
  3. raw_sel[i]=1 → raw pattern.
  4. Otherwise → hex decode of nibble i (standard 0-9, A, b, C, d, E, F glyphs).
- Output polarity: the result is inverted when ACTIVE_LOW=1.
- Output timing:
  - hex_out is registered.
  - A register write at edge N is visible on hex_out after edge N+1.
  - A blink_phase change at edge N is visible after edge N+1.
- Reset:
  - hex_out = all segments off (all ones when ACTIVE_LOW=1), asserted asynchronously.
  - On the first edge after deassert, hex_out shows "0" on every implemented digit.
- Reset mid-operation: all registers, counter, phase and hex_out return to reset values immediately. No partial write survives.
- Simultaneous CTRL write and counter wrap: the write's restart wins (counter=0, phase=0).
- readdata reflects register contents as of the current cycle. A read in the same cycle as a write to the same register returns the old value.

Decomposition:
- Package hex_display_pkg holds:
  - register address constants (ADDR_VALUE, ADDR_CTRL, ADDR_RAW_LO, ADDR_RAW_HI, ADDR_STATUS);
  - CTRL field offsets;
  - segment glyph constant table (16 x 7 bits, active-high).
- One sub-module, seg7_decode: combinational 4-bit nibble → 7-bit active-high pattern from the package table. Instantiated NUM_DIGITS times.
- Blink timer and register file stay in the top module.

Test Plan:
All scenarios use NUM_DIGITS=6, BLINK_DIV=4, ACTIVE_LOW=1.
1. Reset: assert reset_n=0 → hex_out=42'h3FF_FFFF_FFFF immediately. After deassert plus 1 clk, every digit = 7'h40. Read CTRL → 0x0000003F.
2. Write VALUE=0x000000A1, byteenable=4'b0001 → next-next edge: digit0=7'h79, digit1=7'h08, others 7'h40. Read VALUE → 0x000000A1. Write 0xFFFFFFFF with byteenable=4'b0010 → reads 0x0000FFA1; digits 2,3 = 7'h0E ("F").
3. Raw mode: write RAW_LO=0x00000055, then CTRL=0x0001003F → digit0 = 7'h2A. Write RAW_LO byte0=0xFF → readback byte0 = 0x7F.
4. Blink: write CTRL=0x0000023F → digit1 lit 4 clks, 7'h7F for 4 clks, repeating. STATUS bit0 toggles every 4 clks. Rewrite CTRL mid-off-phase → digit1 lit again 2 edges later.
5. Enable/priority: CTRL=0x0001023E with RAW_LO=0x55 → digit0=7'h7F permanently, regardless of raw or blink. Write to address 6 and a read of address 5 → no state change; readdata=0.
6. Reset mid-blink: phase=1, reset_n pulsed low for 1 clk → hex_out all ones during reset. STATUS=0, VALUE=0, CTRL=0x3F afterwards. Blink restarts at counter 0.

Source files
------------

// File: rtl/hex_display_ctrl_pkg.sv
// Shared constants for the hex display controller: register map, CTRL layout, glyph table.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package hex_display_pkg;

  // Register word addresses
  localparam logic [2:0] ADDR_VALUE  = 3'd0;
  localparam logic [2:0] ADDR_CTRL   = 3'd1;
  localparam logic [2:0] ADDR_RAW_LO = 3'd2;
  localparam logic [2:0] ADDR_RAW_HI = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  // CTRL field offsets; the blink mask lives in byte lane 1, and a write to
  // that lane restarts the blink timer.
  localparam int CTRL_EN_LSB     = 0;
  localparam int CTRL_BLINK_LSB  = 8;
  localparam int CTRL_RAW_LSB    = 16;
  localparam int CTRL_BLINK_LANE = 1;

  typedef struct packed {
    logic [7:0] rsvd;
    logic [7:0] raw_sel;
    logic [7:0] blink;
    logic [7:0] enable;
  } ctrl_t;

  // Active-high glyphs, bit0 = seg a .. bit6 = seg g; index 0 is the rightmost entry.
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Replace only the byte lanes selected by be.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_val[8*b +: 8];
    return r;
  endfunction

  // One bit per implemented digit.
  function automatic logic [7:0] digit_mask(input int num_digits);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++)
      if (i < num_digits) m[i] = 1'b1;
    return m;
  endfunction

  // One nibble per implemented digit.
  function automatic logic [31:0] value_mask(input int num_digits);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 8; i++)
      if (i < num_digits) m[4*i +: 4] = 4'hF;
    return m;
  endfunction

  // Seven pattern bits per implemented digit in a RAW word starting at digit base.
  function automatic logic [31:0] raw_mask(input int base, input int num_digits);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++)
      if (base + k < num_digits) m[8*k +: 8] = 8'h7F;
    return m;
  endfunction

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Avalon-MM slave bus bundle for the hex display controller.
// Latency: readdata is combinational from address (zero wait states).
// Backpressure: none; every access completes in the cycle it is presented.
interface hex_display_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, byteenable, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, byteenable, writedata,
    output readdata
  );
endinterface

// File: rtl/hex_display_ctrl_seg7_decode.sv
// Hex nibble to active-high seven-segment pattern.
// Latency: combinational.
// Backpressure: none.
module seg7_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_GLYPH[nibble];

endmodule

// File: rtl/hex_display_ctrl.sv
// Memory-mapped seven-segment controller: hex/raw per digit, per-digit enable and hardware blink.
// Latency: register write or blink phase change shows on hex_out one edge later; reads are combinational.
// Backpressure: none; zero-wait-state slave.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  hex_display_ctrl_if.slave       bus,
  output logic [NUM_DIGITS*7-1:0] hex_out
);

  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  // Bits for digits that do not exist are held at zero so they read back 0.
  localparam logic [7:0]  DIG_MASK    = digit_mask(NUM_DIGITS);
  localparam logic [31:0] VALUE_MASK  = value_mask(NUM_DIGITS);
  localparam logic [31:0] CTRL_MASK   = {8'h00, DIG_MASK, DIG_MASK, DIG_MASK};
  localparam logic [31:0] RAW_LO_MASK = raw_mask(0, NUM_DIGITS);
  localparam logic [31:0] RAW_HI_MASK = raw_mask(4, NUM_DIGITS);
  localparam ctrl_t       CTRL_RESET  = '{rsvd: 8'h00, raw_sel: 8'h00, blink: 8'h00, enable: DIG_MASK};

  logic [31:0]            value_q;
  ctrl_t                  ctrl_q;
  logic [31:0]            raw_lo_q;
  logic [31:0]            raw_hi_q;
  logic [CNT_W-1:0]       blink_cnt;
  logic                   blink_phase;
  logic [NUM_DIGITS*7-1:0] seg_lit;

  logic wr_en;
  logic blink_restart;

  assign wr_en = bus.chipselect && !bus.write_n;
  assign blink_restart = wr_en && (bus.address == ADDR_CTRL) && bus.byteenable[CTRL_BLINK_LANE];

  // Register file: byte-lane writes, unimplemented bits masked off on every write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q  <= '0;
      ctrl_q   <= CTRL_RESET;
      raw_lo_q <= '0;
      raw_hi_q <= '0;
    end else if (wr_en) begin
      case (bus.address)
        ADDR_VALUE:  value_q  <= byte_merge(value_q, bus.writedata, bus.byteenable) & VALUE_MASK;
        ADDR_CTRL:   ctrl_q   <= ctrl_t'(byte_merge(ctrl_q, bus.writedata, bus.byteenable) & CTRL_MASK);
        ADDR_RAW_LO: raw_lo_q <= byte_merge(raw_lo_q, bus.writedata, bus.byteenable) & RAW_LO_MASK;
        ADDR_RAW_HI: raw_hi_q <= byte_merge(raw_hi_q, bus.writedata, bus.byteenable) & RAW_HI_MASK;
        default: ;
      endcase
    end
  end

  // Blink timer: phase toggles on each wrap; touching the blink mask restarts it so
  // newly blinking digits begin lit for a full half-period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_restart) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == CNT_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + CNT_W'(1);
    end
  end

  // Read mux: pre-edge register contents, zero for unmapped addresses.
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_VALUE:  bus.readdata = value_q;
      ADDR_CTRL:   bus.readdata = ctrl_q;
      ADDR_RAW_LO: bus.readdata = raw_lo_q;
      ADDR_RAW_HI: bus.readdata = raw_hi_q;
      ADDR_STATUS: bus.readdata = {31'b0, blink_phase};
      default:     bus.readdata = '0;
    endcase
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [6:0] glyph;
    logic [6:0] raw_pat;

    seg7_decode u_dec (
      .nibble (value_q[4*gi +: 4]),
      .seg    (glyph)
    );

    if (gi < 4) begin : g_lo
      assign raw_pat = raw_lo_q[8*gi +: 7];
    end else begin : g_hi
      assign raw_pat = raw_hi_q[8*(gi-4) +: 7];
    end

    // Disable beats blink, blink beats raw, raw beats hex.
    assign seg_lit[7*gi +: 7] =
        !ctrl_q.enable[gi]                  ? 7'h00   :
        (ctrl_q.blink[gi] && blink_phase)   ? 7'h00   :
        ctrl_q.raw_sel[gi]                  ? raw_pat :
                                              glyph;
  end

  // Output register with panel polarity applied; reset shows every segment dark.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      hex_out <= {(NUM_DIGITS*7){ACTIVE_LOW}};
    else
      hex_out <= ACTIVE_LOW ? ~seg_lit : seg_lit;
  end

endmodule
